dcounter_sched: RTL and testbench
=================================

# dcounter_sched

Two-requester scheduler that shares a single `dcounter` instance between two clients. It waits for the counter's `rdy` and drives `d_en` high for a per-request window. It then lets the count settle, captures `d_out`, and returns the value to the granted requester with a one-cycle `done` pulse. It sits between the client logic and the `dcounter` DUT, and owns the counter's `d_en` exclusively.

## Interface
Parameters:
- `WW`, 16: width of the window-length inputs.
- `SETTLE`, 2: idle cycles between `d_en` falling and `d_out` capture; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `req`  in  2  level request per client; `req[i]` is held until `done[i]`.
- `win0`  in  WW  run-window length for client 0, sampled at grant.
- `win1`  in  WW  run-window length for client 1, sampled at grant.
- `gnt`  out  2  one-hot grant, high from grant through the `done` cycle.
- `done`  out  2  one-cycle pulse to the served client; `result` is valid in that cycle.
- `err`  out  1  high together with `done` when a service was aborted.
- `result`  out  16  captured counter value; holds until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `cnt_en`  out  1  drives `dcounter.d_en`.
- `cnt_rdy`  in  1  from `dcounter.rdy`.
- `cnt_val`  in  16  from `dcounter.d_out`.

## Operation
- FSM states are IDLE, WAIT_RDY, RUN, SETTLE, DONE. All outputs are registered.
- **IDLE:** when any `req` bit is high, the block picks a winner, latches that client's window into `wcnt`, sets `gnt` and goes to WAIT_RDY.
- **Arbitration:** round-robin on a last-served pointer `lp`. `lp` resets to 1, so client 0 wins the first tie. On a tie the client not equal to `lp` wins. `lp` updates in DONE.
- **Window value:** a latched window of 0 is treated as 1.
- **WAIT_RDY:** stays until `cnt_rdy`=1, then goes to RUN with `cnt_en`=1. There is no timeout.
- **RUN:** `cnt_en` stays high for exactly `wcnt` cycles, with a down-counter decremented each cycle. At 1 the block goes to SETTLE and `cnt_en`=0.
  - If `cnt_rdy`=0 in any RUN cycle, the block drops `cnt_en` next edge, goes to DONE with `err`=1, and does not update `result`.
- **SETTLE:** waits `SETTLE` cycles with `cnt_en`=0. On the edge leaving SETTLE, `result` takes `cnt_val` and the block goes to DONE.
- **DONE:** `done[g]`=1 and `err` as set, for one cycle. Next edge: `gnt`=0, `done`=0, `err`=0, `lp`=g, go to IDLE.
- **Request handling:**
  - A `req` drop after grant is ignored; the service completes and `done` still pulses.
  - A `req` from the other client waits, so there is no pre-emption.
  - `win0`/`win1` changes after grant have no effect.
- **Reset:** asynchronous; can be asserted mid-operation in any state.
  - Immediately: state=IDLE, `cnt_en`=0, `gnt`=0, `done`=0, `err`=0, `busy`=0, `result`=0, `lp`=1, counters=0.
  - A service interrupted by reset produces no `done`.

## Timing
- **Grant:** request seen at edge E0 → `gnt`/`busy` high after E0.
- **Start of run:** with `cnt_rdy` already high, `cnt_en` rises after E1 and stays high for exactly W cycles (W = max(win,1)).
- **Capture:** after `SETTLE` cycles, `result` is captured at edge E1+W+SETTLE, and `done` is high in the following cycle.
- **Total service latency:** W+SETTLE+2 cycles from the grant edge to the `done` cycle, plus any cycles spent waiting for `cnt_rdy`.
- **Back-to-back:** there is at least one IDLE cycle between services. The next `gnt` rises 2 cycles after the previous `done` cycle.
- **Window width:** `wcnt` is WW bits wide. The maximum window is 2^WW−1 cycles, with no wrap.

## Test plan
- **Single request:** reset low 2 cycles; `cnt_rdy`=1; `req`=01, `win0`=5 → `gnt`=01 next cycle, `cnt_en` high exactly 5 cycles, `done`=01 at cycle 9 after the grant edge (SETTLE=2), `result`=`cnt_val` sampled at capture, `err`=0.
- **Tie and fairness:** `req`=11 held, `win0`=3, `win1`=4 → order is client 0, 1, 0, 1. `cnt_en` pulses alternate 3/4 cycles. Each `done` is one-hot and matches `gnt`.
- **Late rdy and window 0:** `cnt_rdy`=0 for 10 cycles after grant, `win1`=0 → `busy`=1 and `cnt_en`=0 throughout the wait, then `cnt_en` is high for exactly 1 cycle.
- **Abort:** `win0`=20, `cnt_rdy` dropped in RUN cycle 6 → `cnt_en` low next cycle, `done`=01 with `err`=1, `result` unchanged from its prior value.
- **Reset mid-RUN:** `rst`=0 at RUN cycle 3 → all outputs are 0 immediately with no `done`. After release, `req`=11 is granted to client 0.
- **Request withdrawn:** `req[0]` drops 1 cycle after grant → service completes normally, `done`=01 pulses, no re-grant to client 0.

Source files
------------

// File: rtl/dcounter_sched.sv
// dcounter_sched: round-robin two-client scheduler sharing one dcounter.
// Grants a client, runs the counter for its window, waits for the count to settle and returns the captured value.
module dcounter_sched #(
  parameter int WW     = 16,
  parameter int SETTLE = 2
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [WW-1:0] win0,
  input  logic [WW-1:0] win1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [15:0]   result,
  output logic          busy,
  output logic          cnt_en,
  input  logic          cnt_rdy,
  input  logic [15:0]   cnt_val
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [2:0]    r_state;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;
  logic          r_err;
  logic          r_busy;
  logic          r_cnt_en;
  logic          r_lp;
  logic [15:0]   r_result;
  logic [WW-1:0] r_wcnt;
  logic [3:0]    r_scnt;

  logic          w_pick1;
  logic [WW-1:0] w_win;
  logic [WW-1:0] w_win_eff;

  // On a tie the client that was not served last wins.
  assign w_pick1   = req[1] & (~req[0] | ~r_lp);
  assign w_win     = w_pick1 ? win1 : win0;
  assign w_win_eff = (w_win == '0) ? WW'(1) : w_win;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt_en <= 1'b0;
      r_lp     <= 1'b1;
      r_result <= 16'd0;
      r_wcnt   <= '0;
      r_scnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
            r_wcnt  <= w_win_eff;
            r_busy  <= 1'b1;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (cnt_rdy) begin
            r_cnt_en <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Losing rdy mid-window aborts the service; the old result is kept.
          if (!cnt_rdy) begin
            r_cnt_en <= 1'b0;
            r_err    <= 1'b1;
            r_done   <= r_gnt;
            r_state  <= S_DONE;
          end else if (r_wcnt == WW'(1)) begin
            r_cnt_en <= 1'b0;
            r_scnt   <= SETTLE_LD;
            r_state  <= S_SETTLE;
          end else begin
            r_wcnt <= r_wcnt - WW'(1);
          end
        end
        S_SETTLE: begin
          if (r_scnt == 4'd1) begin
            r_result <= cnt_val;
            r_done   <= r_gnt;
            r_state  <= S_DONE;
          end else begin
            r_scnt <= r_scnt - 4'd1;
          end
        end
        S_DONE: begin
          r_gnt   <= 2'b00;
          r_done  <= 2'b00;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_lp    <= r_gnt[1];
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= 2'b00;
          r_done   <= 2'b00;
          r_err    <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt_en <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;
  assign busy   = r_busy;
  assign cnt_en = r_cnt_en;

endmodule

// File: tb/tb_dcounter_sched.sv
// Scoreboard bench for dcounter_sched: stimulus queues expected services, a negedge monitor checks them.
module tb_dcounter_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] win0 = 16'd0;
  logic [15:0] win1 = 16'd0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [15:0] result;
  logic        busy;
  logic        cnt_en;
  logic        cnt_rdy = 1'b1;
  logic [15:0] cnt_val = 16'd0;
  logic        cnt_clr = 1'b0;

  dcounter_sched #(.WW(16), .SETTLE(2)) dut (
    .clock   (clk),
    .rst     (rst_n),
    .req     (req),
    .win0    (win0),
    .win1    (win1),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .result  (result),
    .busy    (busy),
    .cnt_en  (cnt_en),
    .cnt_rdy (cnt_rdy),
    .cnt_val (cnt_val)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for dcounter: counts every cycle d_en is high.
  always @(posedge clk) begin
    if (cnt_clr) cnt_val <= 16'd0;
    else if (cnt_en) cnt_val <= cnt_val + 16'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  d;
    logic        e;
    logic [15:0] r;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   w_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  bit   b2b = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void push(logic [1:0] d, logic e, logic [15:0] r, int lat, int w);
    exp_t x;
    x.d = d; x.e = e; x.r = r; x.lat = lat;
    sb_q.push_back(x);
    w_q.push_back(w);
  endfunction

  // Monitor
  logic [1:0] prev_gnt = 2'b00;
  logic       prev_en = 1'b0;
  int         run_len = 0;
  int         gnt_cyc = 0;
  int         last_done_cyc = 0;
  exp_t       cur;
  int         exp_w;

  always @(negedge clk) begin
    if (cnt_en === 1'b1) begin
      run_len++;
    end else if (prev_en) begin
      if (w_q.size() == 0) chk("en_width_extra", w_q.size(), 1);
      else begin
        exp_w = w_q.pop_front();
        chk("en_width", run_len, exp_w);
      end
      run_len = 0;
    end
    prev_en = (cnt_en === 1'b1);

    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_cyc = cyc;
      if (b2b) chk("b2b_gap", cyc - last_done_cyc, 2);
    end
    prev_gnt = gnt;

    if (done != 2'b00 && rst_n) begin
      $display("done=%b err=%0d result=%0d gnt=%b at cycle %0d", done, err, result, gnt, cyc);
      if (sb_q.size() == 0) chk("done_unexpected", sb_q.size(), 1);
      else begin
        cur = sb_q.pop_front();
        chk("done_client", done, cur.d);
        chk("done_err", err, cur.e);
        chk("done_result", result, cur.r);
        chk("done_matches_gnt", gnt, done);
        chk("latency", cyc - gnt_cyc + 1, cur.lat);
      end
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt == 2'b00 && n < 200) begin tick(); n++; end
    chk("gnt_timeout", (gnt != 2'b00), 1);
  endtask

  task automatic wait_en();
    int n = 0;
    while (cnt_en !== 1'b1 && n < 200) begin tick(); n++; end
    chk("cnt_en_timeout", cnt_en, 1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin tick(); n++; end
    chk("done_timeout", (done_cnt >= target), 1);
  endtask

  task automatic clr_model();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_result", result, 0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int target;
    bit bad;

    // Single request, win0=5: latency 5+2+2
    do_reset();
    cnt_rdy = 1'b1;
    clr_model();
    push(2'b01, 1'b0, 16'd5, 9, 5);
    win0 = 16'd5;
    req = 2'b01;
    wait_gnt();
    chk("single_gnt", gnt, 2'b01);
    chk("single_busy", busy, 1);
    wait_done(1);
    req = 2'b00;
    repeat (3) tick();

    // Tie and fairness from reset: 0,1,0,1 with cumulative counter 3,7,10,14
    do_reset();
    clr_model();
    push(2'b01, 1'b0, 16'd3, 7, 3);
    push(2'b10, 1'b0, 16'd7, 8, 4);
    push(2'b01, 1'b0, 16'd10, 7, 3);
    push(2'b10, 1'b0, 16'd14, 8, 4);
    win0 = 16'd3;
    win1 = 16'd4;
    target = done_cnt + 4;
    req = 2'b11;
    wait_gnt();
    chk("tie_first_gnt", gnt, 2'b01);
    b2b = 1'b1;
    wait_done(target);
    req = 2'b00;
    b2b = 1'b0;
    repeat (3) tick();

    // Late rdy with window 0 on client 1: 10 wait cycles, 1-cycle run
    clr_model();
    cnt_rdy = 1'b0;
    push(2'b10, 1'b0, 16'd1, 15, 1);
    win1 = 16'd0;
    target = done_cnt + 1;
    req = 2'b10;
    wait_gnt();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b1 || cnt_en !== 1'b0) bad = 1'b1;
    end
    chk("late_rdy_wait_ok", bad, 0);
    cnt_rdy = 1'b1;
    wait_done(target);
    req = 2'b00;
    repeat (3) tick();

    // Abort: rdy drops in RUN cycle 6 of a 20-cycle window
    push(2'b01, 1'b1, 16'd1, 8, 6);
    win0 = 16'd20;
    target = done_cnt + 1;
    req = 2'b01;
    wait_gnt();
    wait_en();
    repeat (5) tick();
    cnt_rdy = 1'b0;
    tick();
    chk("abort_en_low", cnt_en, 0);
    wait_done(target);
    req = 2'b00;
    cnt_rdy = 1'b1;
    repeat (3) tick();

    // Request withdrawn one cycle after grant
    clr_model();
    push(2'b01, 1'b0, 16'd4, 8, 4);
    win0 = 16'd4;
    target = done_cnt + 1;
    req = 2'b01;
    wait_gnt();
    tick();
    req = 2'b00;
    wait_done(target);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt !== 2'b00) bad = 1'b1;
    end
    chk("no_regrant", bad, 0);

    // Reset in RUN cycle 3: outputs clear at once, no done
    target = done_cnt;
    w_q.push_back(3);
    win0 = 16'd10;
    req = 2'b01;
    wait_gnt();
    wait_en();
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt_en", cnt_en, 0);
    chk("midrst_result", result, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", done_cnt, target);

    // After reset a tie goes to client 0
    clr_model();
    push(2'b01, 1'b0, 16'd2, 6, 2);
    win0 = 16'd2;
    win1 = 16'd7;
    target = done_cnt + 1;
    req = 2'b11;
    wait_gnt();
    chk("post_rst_gnt", gnt, 2'b01);
    wait_done(target);
    req = 2'b00;
    repeat (5) tick();

    chk("sb_empty", sb_q.size(), 0);
    chk("width_q_empty", w_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
